color_mapper_pipe: RTL and testbench



---
 rtl/color_mapper_pipe_if.sv | 47 ++++
 rtl/color_mapper_pipe.sv | 231 +++++++++++++++++++++++
 tb/tb_color_mapper_pipe.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/color_mapper_pipe_if.sv
// ============================================================================
// Module      : color_mapper_pipe_if
// Description : Pixel, palette-write, flash-control and RGB output bundle
//               for color_mapper_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface color_mapper_pipe_if #(
    parameter int PAL_AW = 3
);
    logic              pix_valid;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              is_shape;
    logic [PAL_AW-1:0] shape_id;
    logic              is_boundary;
    logic              pal_we;
    logic [PAL_AW-1:0] pal_addr;
    logic [23:0]       pal_wdata;
    logic              frame_start;
    logic              flash_req;
    logic [9:0]        flash_y_lo;
    logic [9:0]        flash_y_hi;
    logic [7:0]        VGA_R;
    logic [7:0]        VGA_G;
    logic [7:0]        VGA_B;
    logic              out_valid;
    logic              flash_busy;
    logic              flash_done;

    modport master (
        output pix_valid, DrawX, DrawY, is_shape, shape_id, is_boundary,
               pal_we, pal_addr, pal_wdata, frame_start, flash_req,
               flash_y_lo, flash_y_hi,
        input  VGA_R, VGA_G, VGA_B, out_valid, flash_busy, flash_done
    );

    modport slave (
        input  pix_valid, DrawX, DrawY, is_shape, shape_id, is_boundary,
               pal_we, pal_addr, pal_wdata, frame_start, flash_req,
               flash_y_lo, flash_y_hi,
        output VGA_R, VGA_G, VGA_B, out_valid, flash_busy, flash_done
    );
endinterface

`default_nettype wire

// File: rtl/color_mapper_pipe.sv
// ============================================================================
// Module      : color_mapper_pipe
// Description : Two-stage pipelined Tetris colour mapper with writable
//               palette, saturating background gradient and line-clear
//               flash engine. Optional macro COLOR_MAPPER_BEVEL_EN adds
//               block-edge bevel shading.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module color_mapper_pipe #(
    parameter int          PAL_AW       = 3,
    parameter int          GRAD_SHIFT   = 3,
    parameter logic [23:0] BG_RGB       = 24'h3F007F,
    parameter logic [23:0] BOUNDARY_RGB = 24'h000000,
    parameter int          BLINK_FRAMES = 4,
    parameter int          FLASH_FRAMES = 24,
    parameter int          BLOCK_SHIFT  = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    color_mapper_pipe_if.slave   bus
);

    localparam int          PAL_N      = 2 ** PAL_AW;
    localparam int          FCW        = $clog2(FLASH_FRAMES + 1);
    localparam int          PCW        = $clog2(BLINK_FRAMES + 1);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FLASH_FRAMES - 1);
    localparam logic [PCW-1:0] PHASE_LAST = PCW'(BLINK_FRAMES - 1);
    localparam logic [7:0]  BG_B       = BG_RGB[7:0];
    localparam logic [23:0] WHITE_RGB  = 24'hFFFFFF;
    localparam logic [23:0] PAL_RESET  = 24'h808080;

    generate
        if (BLOCK_SHIFT < 1 || BLOCK_SHIFT > 10 || BLINK_FRAMES < 1 || FLASH_FRAMES < 1) begin : g_bad_params
            $error("color_mapper_pipe: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } flash_state_t;

    flash_state_t     state;
    logic             busy;
    logic             done;
    logic [FCW-1:0]   frame_cnt;
    logic [PCW-1:0]   phase_cnt;
    logic [9:0]       band_lo;
    logic [9:0]       band_hi;

    logic [23:0]      pal [PAL_N];

    logic             v1;
    logic [9:0]       x1;
    logic             shape1;
    logic             bnd1;
    logic [23:0]      pal1;
    logic             white1;
    logic             hide1;
`ifdef COLOR_MAPPER_BEVEL_EN
    logic [9:0]       y1;
`endif

    logic             v2;
    logic [23:0]      rgb2;

    logic             in_band;
    logic [10:0]      bg_dec;
    logic [23:0]      bg_rgb;
    logic [23:0]      shape_rgb;
    logic [23:0]      rgb_next;

    // ---------------- Flash sequencer ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
            phase_cnt <= '0;
            band_lo   <= '0;
            band_hi   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // frame_start in the same cycle as the request is not counted
                    if (bus.flash_req && (bus.flash_y_lo <= bus.flash_y_hi)) begin
                        state     <= ST_ON;
                        busy      <= 1'b1;
                        band_lo   <= bus.flash_y_lo;
                        band_hi   <= bus.flash_y_hi;
                        frame_cnt <= '0;
                        phase_cnt <= '0;
                    end
                end
                ST_ON, ST_OFF: begin
                    if (bus.frame_start) begin
                        if (frame_cnt == FRAME_LAST) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            frame_cnt <= '0;
                            phase_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                            if (phase_cnt == PHASE_LAST) begin
                                phase_cnt <= '0;
                                state     <= (state == ST_ON) ? ST_OFF : ST_ON;
                            end else begin
                                phase_cnt <= phase_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- Palette ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < PAL_N; i++) begin
                pal[i] <= PAL_RESET;
            end
        end else if (bus.pal_we) begin
            pal[bus.pal_addr] <= bus.pal_wdata;
        end
    end

    // ---------------- Stage 1 ----------------
    assign in_band = (bus.DrawY >= band_lo) && (bus.DrawY <= band_hi);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            v1     <= 1'b0;
            x1     <= '0;
            shape1 <= 1'b0;
            bnd1   <= 1'b0;
            pal1   <= '0;
            white1 <= 1'b0;
            hide1  <= 1'b0;
        end else begin
            v1     <= bus.pix_valid;
            x1     <= bus.DrawX;
            shape1 <= bus.is_shape;
            bnd1   <= bus.is_boundary;
            pal1   <= pal[bus.shape_id];
            white1 <= bus.is_shape && in_band && (state == ST_ON);
            hide1  <= bus.is_shape && in_band && (state == ST_OFF);
        end
    end

`ifdef COLOR_MAPPER_BEVEL_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            y1 <= '0;
        end else begin
            y1 <= bus.DrawY;
        end
    end

    function automatic logic [7:0] ch_adj(input logic [7:0] c, input logic up);
        if (up) begin
            return (c > 8'hBF) ? 8'hFF : c + 8'h40;
        end
        return (c < 8'h40) ? 8'h00 : c - 8'h40;
    endfunction

    logic bev_bright;
    logic bev_dark;
    assign bev_bright = (x1[BLOCK_SHIFT-1:0] == '0) || (y1[BLOCK_SHIFT-1:0] == '0);
    assign bev_dark   = (&x1[BLOCK_SHIFT-1:0]) || (&y1[BLOCK_SHIFT-1:0]);

    always_comb begin
        shape_rgb = pal1;
        if (bev_bright || bev_dark) begin
            shape_rgb = {ch_adj(pal1[23:16], bev_bright),
                         ch_adj(pal1[15:8],  bev_bright),
                         ch_adj(pal1[7:0],   bev_bright)};
        end
    end
`else
    assign shape_rgb = pal1;
`endif

    // ---------------- Stage 2 ----------------
    // Blue decrement is compared at full width so large shifts saturate instead of wrapping
    assign bg_dec = {1'b0, x1} >> GRAD_SHIFT;
    assign bg_rgb = {BG_RGB[23:8], (bg_dec > {3'b000, BG_B}) ? 8'h00 : BG_B - bg_dec[7:0]};

    always_comb begin
        rgb_next = bg_rgb;
        if (white1) begin
            rgb_next = WHITE_RGB;
        end else if (hide1) begin
            rgb_next = bg_rgb;
        end else if (shape1) begin
            rgb_next = shape_rgb;
        end else if (bnd1) begin
            rgb_next = BOUNDARY_RGB;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            v2   <= 1'b0;
            rgb2 <= '0;
        end else begin
            v2   <= v1;
            rgb2 <= rgb_next;
        end
    end

    assign bus.VGA_R      = rgb2[23:16];
    assign bus.VGA_G      = rgb2[15:8];
    assign bus.VGA_B      = rgb2[7:0];
    assign bus.out_valid  = v2;
    assign bus.flash_busy = busy;
    assign bus.flash_done = done;

endmodule

`default_nettype wire

// File: tb/tb_color_mapper_pipe.sv
// ============================================================================
// Module      : tb_color_mapper_pipe
// Description : Self-checking bench for color_mapper_pipe (default and
//               GRAD_SHIFT=0 instances) against a frame-counting model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_color_mapper_pipe;

    localparam int PAL_AW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    color_mapper_pipe_if #(.PAL_AW(PAL_AW)) bus0 ();
    color_mapper_pipe_if #(.PAL_AW(PAL_AW)) bus1 ();

    assign bus1.pix_valid   = bus0.pix_valid;
    assign bus1.DrawX       = bus0.DrawX;
    assign bus1.DrawY       = bus0.DrawY;
    assign bus1.is_shape    = bus0.is_shape;
    assign bus1.shape_id    = bus0.shape_id;
    assign bus1.is_boundary = bus0.is_boundary;
    assign bus1.pal_we      = bus0.pal_we;
    assign bus1.pal_addr    = bus0.pal_addr;
    assign bus1.pal_wdata   = bus0.pal_wdata;
    assign bus1.frame_start = bus0.frame_start;
    assign bus1.flash_req   = bus0.flash_req;
    assign bus1.flash_y_lo  = bus0.flash_y_lo;
    assign bus1.flash_y_hi  = bus0.flash_y_hi;

    color_mapper_pipe #(.PAL_AW(PAL_AW)) u_dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus0.slave)
    );

    color_mapper_pipe #(.PAL_AW(PAL_AW), .GRAD_SHIFT(0)) u_dut_g0 (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus1.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: palette contents, flash as "frames counted since start"
    logic [23:0] mpal [8];
    bit          mbusy;
    int          mframes;
    int          mlo, mhi;
    bit          mdone;
    bit          hv;
    logic [23:0] hrgb0, hrgb1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

`ifdef COLOR_MAPPER_BEVEL_EN
    function automatic logic [23:0] bevel(input logic [23:0] c, input int x, input int y);
        int d;
        int v;
        logic [23:0] r;
        d = 0;
        if (x % 16 == 0 || y % 16 == 0) d = 64;
        else if (x % 16 == 15 || y % 16 == 15) d = -64;
        for (int i = 0; i < 3; i++) begin
            v = int'(c[i*8 +: 8]) + d;
            if (v > 255) v = 255;
            if (v < 0) v = 0;
            r[i*8 +: 8] = 8'(v);
        end
        return r;
    endfunction
`endif

    function automatic logic [23:0] model_pixel(input int gs);
        int x, y, b;
        logic [23:0] bg;
        x = int'(bus0.DrawX);
        y = int'(bus0.DrawY);
        b = 127 - (x >> gs);
        if (b < 0) b = 0;
        bg = {16'h3F00, 8'(b)};
        if (bus0.is_shape) begin
            if (mbusy && y >= mlo && y <= mhi)
                return ((mframes / 4) % 2 == 0) ? 24'hFFFFFF : bg;
`ifdef COLOR_MAPPER_BEVEL_EN
            return bevel(mpal[bus0.shape_id], x, y);
`else
            return mpal[bus0.shape_id];
`endif
        end
        if (bus0.is_boundary) return 24'h000000;
        return bg;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mpal[i] = 24'h808080;
        mbusy = 0; mframes = 0; mlo = 0; mhi = 0; mdone = 0;
        hv = 0; hrgb0 = '0; hrgb1 = '0;
    endtask

    task automatic set_idle();
        bus0.pix_valid = 0; bus0.DrawX = '0; bus0.DrawY = '0;
        bus0.is_shape = 0; bus0.shape_id = '0; bus0.is_boundary = 0;
        bus0.pal_we = 0; bus0.pal_addr = '0; bus0.pal_wdata = '0;
        bus0.frame_start = 0; bus0.flash_req = 0;
        bus0.flash_y_lo = '0; bus0.flash_y_hi = '0;
    endtask

    task automatic pix(input int x, input int y, input bit shp, input int id, input bit bnd);
        bus0.pix_valid = 1; bus0.DrawX = 10'(x); bus0.DrawY = 10'(y);
        bus0.is_shape = shp; bus0.shape_id = 3'(id); bus0.is_boundary = bnd;
    endtask

    // One clock: model expectation of current inputs, edge, then compare outputs
    task automatic tick();
        logic [23:0] e0, e1;
        bit v;
        e0 = model_pixel(3);
        e1 = model_pixel(0);
        v  = bus0.pix_valid;
        @(posedge clk);
        #1;
        mdone = 0;
        if (bus0.pal_we) mpal[bus0.pal_addr] = bus0.pal_wdata;
        if (!mbusy) begin
            if (bus0.flash_req && bus0.flash_y_lo <= bus0.flash_y_hi) begin
                mbusy = 1; mframes = 0;
                mlo = int'(bus0.flash_y_lo); mhi = int'(bus0.flash_y_hi);
            end
        end else if (bus0.frame_start) begin
            mframes++;
            if (mframes == 24) begin mbusy = 0; mdone = 1; end
        end
        check("out_valid", 32'(bus0.out_valid), 32'(hv));
        check("out_valid_g0", 32'(bus1.out_valid), 32'(hv));
        if (hv) begin
            check("rgb", 32'({bus0.VGA_R, bus0.VGA_G, bus0.VGA_B}), 32'(hrgb0));
            check("rgb_g0", 32'({bus1.VGA_R, bus1.VGA_G, bus1.VGA_B}), 32'(hrgb1));
        end
        check("flash_busy", 32'(bus0.flash_busy), 32'(mbusy));
        check("flash_done", 32'(bus0.flash_done), 32'(mdone));
        hv = v; hrgb0 = e0; hrgb1 = e1;
    endtask

    task automatic lit(input string name, input logic [23:0] exp);
        check(name, 32'({bus0.VGA_R, bus0.VGA_G, bus0.VGA_B}), 32'(exp));
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_rgb"}, 32'({bus0.VGA_R, bus0.VGA_G, bus0.VGA_B}), 32'h0);
        check({name, "_valid"}, 32'(bus0.out_valid), 32'h0);
        check({name, "_busy"}, 32'(bus0.flash_busy), 32'h0);
        check({name, "_done"}, 32'(bus0.flash_done), 32'h0);
    endtask

    task automatic do_reset(input string name);
        rst = 1;
        #1;
        check_zero_outputs(name);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic frame_pulse();
        bus0.frame_start = 1; tick(); bus0.frame_start = 0; tick();
    endtask

    initial begin
        set_idle();
        model_reset();
        @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 0;

        // Default palette entry
        pix(50, 300, 1, 3, 0); tick(); set_idle(); tick();
        lit("pal_default", 24'h808080);

        // Write and read of the same address in one cycle returns the old value
        pix(50, 300, 1, 5, 0);
        bus0.pal_we = 1; bus0.pal_addr = 3'd5; bus0.pal_wdata = 24'h12AB34;
        tick();
        bus0.pal_we = 0;
        tick();
        lit("pal_old", 24'h808080);
        set_idle(); tick();
        lit("pal_new", 24'h12AB34);

        // Background gradient
        pix(0, 300, 0, 0, 0); tick(); set_idle(); tick();
        lit("bg_x0", 24'h3F007F);
        pix(639, 300, 0, 0, 0); tick(); set_idle(); tick();
        lit("bg_x639", 24'h3F0030);
        check("bg_x639_gs0", 32'({bus1.VGA_R, bus1.VGA_G, bus1.VGA_B}), 32'h3F0000);
        pix(20, 20, 0, 0, 1); tick(); set_idle(); tick();
        lit("boundary", 24'h000000);

        // Reset mid-stream also restores the palette
        pix(50, 300, 1, 5, 0); tick();
        do_reset("rst_mid");
        tick(); tick();
        pix(50, 300, 1, 5, 0); tick(); set_idle(); tick();
        lit("pal_after_rst", 24'h808080);

        // Inverted band is ignored
        bus0.flash_req = 1; bus0.flash_y_lo = 10'd200; bus0.flash_y_hi = 10'd100;
        tick(); set_idle();
        check("inv_band_busy", 32'(bus0.flash_busy), 32'h0);

        // Start with a coincident frame_start, which does not count
        bus0.flash_req = 1; bus0.frame_start = 1;
        bus0.flash_y_lo = 10'd100; bus0.flash_y_hi = 10'd115;
        tick(); set_idle();
        check("start_busy", 32'(bus0.flash_busy), 32'h1);
        pix(0, 105, 1, 2, 0); tick(); set_idle(); tick();
        lit("flash_on", 24'hFFFFFF);
        pix(0, 120, 1, 2, 0); tick(); set_idle(); tick();
        lit("outside_band", 24'h808080);
        bus0.flash_req = 1; bus0.flash_y_lo = 10'd0; bus0.flash_y_hi = 10'd1023;
        tick(); set_idle();
        for (int f = 0; f < 4; f++) frame_pulse();
        pix(0, 105, 1, 2, 0); tick(); set_idle(); tick();
        lit("flash_off", 24'h3F007F);
        for (int f = 0; f < 19; f++) frame_pulse();
        check("busy_before_end", 32'(bus0.flash_busy), 32'h1);
        bus0.frame_start = 1; tick(); bus0.frame_start = 0;
        check("done_pulse", 32'(bus0.flash_done), 32'h1);
        check("busy_after_end", 32'(bus0.flash_busy), 32'h0);
        tick();
        check("done_single", 32'(bus0.flash_done), 32'h0);
        pix(0, 120, 1, 2, 0); tick(); set_idle(); tick();
        lit("after_seq", 24'h808080);

        // Reset during the OFF phase
        bus0.flash_req = 1; bus0.flash_y_lo = 10'd100; bus0.flash_y_hi = 10'd115;
        tick(); set_idle();
        for (int f = 0; f < 5; f++) frame_pulse();
        do_reset("rst_off");
        tick(); tick();

`ifdef COLOR_MAPPER_BEVEL_EN
        bus0.pal_we = 1; bus0.pal_addr = 3'd1; bus0.pal_wdata = 24'hF0F0F0;
        tick(); bus0.pal_we = 0;
        pix(0, 5, 1, 1, 0); tick(); set_idle(); tick();
        lit("bevel_bright", 24'hFFFFFF);
        pix(15, 5, 1, 1, 0); tick(); set_idle(); tick();
        lit("bevel_dark", 24'hB0B0B0);
`endif

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            bus0.pix_valid   = ($urandom_range(0, 3) != 0);
            bus0.DrawX       = 10'($urandom_range(0, 1023));
            bus0.DrawY       = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                           : 10'($urandom_range(90, 130));
            bus0.is_shape    = 1'($urandom_range(0, 1));
            bus0.shape_id    = 3'($urandom_range(0, 7));
            bus0.is_boundary = 1'($urandom_range(0, 1));
            bus0.pal_we      = ($urandom_range(0, 15) == 0);
            bus0.pal_addr    = 3'($urandom_range(0, 7));
            bus0.pal_wdata   = 24'($urandom);
            bus0.frame_start = ($urandom_range(0, 7) == 0);
            bus0.flash_req   = ($urandom_range(0, 40) == 0);
            bus0.flash_y_lo  = 10'($urandom_range(90, 130));
            bus0.flash_y_hi  = 10'($urandom_range(90, 130));
            if ($urandom_range(0, 999) == 0) do_reset("rst_rand");
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
